// File: rtl/iecdrv_shared_rom_pkg.sv
// Shared types and helpers for the multi-drive ROM block: slot-count clamp,
// fetch address masking and detected-size encodings.
package iecdrv_shared_rom_pkg;

    localparam logic [1:0] ROM_SZ_32K = 2'b11;
    localparam logic [1:0] ROM_SZ_16K = 2'b01;
    localparam logic [1:0] ROM_SZ_8K  = 2'b00;

    function automatic int ndr_clamp(input int drives);
        if (drives < 1) begin
            return 1;
        end else if (drives > 4) begin
            return 4;
        end else begin
            return drives;
        end
    endfunction

    // Smaller alternate ROMs mirror through the unused upper address bits.
    function automatic logic [14:0] rom_addr_mask(input logic [14:0] a,
                                                  input logic [1:0]  sz,
                                                  input logic        stdrom);
        return {a[14] & sz[1], a[13] & (sz[0] | stdrom), a[12:0]};
    endfunction

endpackage

// File: rtl/iecdrv_dpram.sv
// Dual-port RAM: port A read/write with one-clock read, port B read-only with
// optional registered address ahead of the registered output.
module iecdrv_dpram #(
    parameter int DATAWIDTH = 8,
    parameter int ADDRWIDTH = 14,
    parameter int B_LATENCY = 2
) (
    input  logic                 clk,
    input  logic [ADDRWIDTH-1:0] addr_a,
    input  logic [DATAWIDTH-1:0] data_a,
    input  logic                 wr_a,
    output logic [DATAWIDTH-1:0] q_a,
    input  logic [ADDRWIDTH-1:0] addr_b,
    output logic [DATAWIDTH-1:0] q_b
);

    logic [DATAWIDTH-1:0] mem_r [0:(2**ADDRWIDTH)-1];
    logic [ADDRWIDTH-1:0] addr_b_s;

    // Port A: loader write and one-clock readback (contents survive reset).
    always_ff @(posedge clk) begin
        if (wr_a) begin
            mem_r[addr_a] <= data_a;
        end
        q_a <= mem_r[addr_a];
    end

    generate
        if (B_LATENCY >= 2) begin : g_addr_reg
            logic [ADDRWIDTH-1:0] addr_b_r;
            // Port B address register.
            always_ff @(posedge clk) begin
                addr_b_r <= addr_b;
            end
            assign addr_b_s = addr_b_r;
        end else begin : g_addr_comb
            assign addr_b_s = addr_b;
        end
    endgenerate

    // Port B registered read data.
    always_ff @(posedge clk) begin
        q_b <= mem_r[addr_b_s];
    end

endmodule

// File: rtl/iecdrv_shared_rom.sv
// Shared 1541 drive ROM: standard and alternate images, phi2 strobe generator,
// alternate-ROM size detection and a per-phi2 fetch sequencer for up to four drives.
module iecdrv_shared_rom
    import iecdrv_shared_rom_pkg::*;
#(
    parameter int DRIVES  = 2,
    parameter bit DUALROM = 1'b1,
    parameter bit PARPORT = 1'b1
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               ce,
    input  logic                               pause,
    output logic                               ph2_r,
    output logic                               ph2_f,
    input  logic [14:0]                        rom_addr_i,
    input  logic [7:0]                         rom_data_i,
    input  logic                               rom_wr_i,
    output logic [7:0]                         rom_data_o,
    input  logic                               rom_std_i,
    input  logic [15*ndr_clamp(DRIVES)-1:0]    drv_addr,
    output logic [8*ndr_clamp(DRIVES)-1:0]     drv_data,
    output logic [1:0]                         rom_sz,
    output logic                               empty8k,
    output logic                               ext_en
);

    localparam int NDR      = ndr_clamp(DRIVES);
    localparam bit ALT_LOAD = DUALROM | PARPORT;

    logic        stdrom_s;
    logic        rom32k_r, rom16k_r;
    logic [3:0]  div_r;
    logic        ena_r, ena1_r;
    logic [2:0]  state_r;
    logic [14:0] mem_a_r;
    logic [14:0] slot_s [0:3];
    logic [14:0] slot_addr_s;
    logic [7:0]  std_qa_s, alt_qa_s, std_qb_s, alt_qb_s, fetch_q_s;

    assign stdrom_s    = ALT_LOAD ? rom_std_i : 1'b1;
    assign ext_en      = rom_sz[1] & empty8k & ~stdrom_s & PARPORT;
    assign rom_data_o  = ALT_LOAD ? alt_qa_s : std_qa_s;
    assign fetch_q_s   = stdrom_s ? std_qb_s : alt_qb_s;
    assign slot_addr_s = slot_s[state_r[1:0]];

    for (genvar k = 0; k < 4; k++) begin : g_slot
        if (k < NDR) begin : g_used
            assign slot_s[k] = drv_addr[15*k +: 15];
        end else begin : g_unused
            assign slot_s[k] = 15'd0;
        end
    end

    // Size detection from loader writes of non-blank data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rom32k_r <= 1'b1;
            rom16k_r <= 1'b1;
            empty8k  <= 1'b1;
            rom_sz   <= ROM_SZ_32K;
        end else begin
            rom_sz <= {rom32k_r, rom32k_r | rom16k_r};
            if (rom_wr_i) begin
                if (rom_addr_i == 15'd0) begin
                    empty8k <= 1'b1;
                end
                if (rom_data_i != 8'h00 && rom_data_i != 8'hFF) begin
                    {rom32k_r, rom16k_r} <= rom_addr_i[14:13];
                    if (rom_addr_i[14:8] != 7'd0 && rom_addr_i[14:13] == 2'd0) begin
                        empty8k <= 1'b0;
                    end
                end
            end
        end
    end

    // phi2 divider; ena only changes away from strobe phases so pause never truncates a pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_r  <= 4'd0;
            ena_r  <= 1'b0;
            ena1_r <= 1'b0;
            ph2_r  <= 1'b0;
            ph2_f  <= 1'b0;
        end else begin
            ena1_r <= ~pause;
            if (div_r[2:0] != 3'd0) begin
                ena_r <= ena1_r;
            end
            if (ce) begin
                div_r <= div_r + 4'd1;
                ph2_r <= ena_r & ~div_r[3] & (div_r[2:0] == 3'd0);
                ph2_f <= ena_r &  div_r[3] & (div_r[2:0] == 3'd0);
            end else begin
                ph2_r <= 1'b0;
                ph2_f <= 1'b0;
            end
        end
    end

    // Fetch sequencer: issue slot addresses in states 0..3, capture bytes in states 3..6.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= 3'd7;
            mem_a_r  <= 15'd0;
            drv_data <= {(8*NDR){1'b0}};
        end else begin
            if (ph2_f) begin
                state_r <= 3'd0;
            end else if (state_r != 3'd7) begin
                state_r <= state_r + 3'd1;
            end
            if (state_r <= 3'd3) begin
                mem_a_r <= rom_addr_mask(slot_addr_s, rom_sz, stdrom_s);
            end
            for (int k = 0; k < NDR; k++) begin
                if (state_r == 3'(k + 3)) begin
                    drv_data[8*k +: 8] <= fetch_q_s;
                end
            end
        end
    end

    iecdrv_dpram #(.DATAWIDTH(8), .ADDRWIDTH(14), .B_LATENCY(2)) u_std (
        .clk    (clk),
        .addr_a (rom_addr_i[13:0]),
        .data_a (rom_data_i),
        .wr_a   (rom_wr_i & ~ALT_LOAD),
        .q_a    (std_qa_s),
        .addr_b (mem_a_r[13:0]),
        .q_b    (std_qb_s)
    );

    iecdrv_dpram #(.DATAWIDTH(8), .ADDRWIDTH(15), .B_LATENCY(2)) u_alt (
        .clk    (clk),
        .addr_a (rom_addr_i),
        .data_a (rom_data_i),
        .wr_a   (rom_wr_i & ALT_LOAD),
        .q_a    (alt_qa_s),
        .addr_b (mem_a_r),
        .q_b    (alt_qb_s)
    );

endmodule

// File: tb/tb_iecdrv_shared_rom.sv
// Directed bench: one instance loading the alternate ROM (dut) and one with
// standard-only loading (dut_s), sharing all inputs.
module tb_iecdrv_shared_rom;

    logic        clk = 1'b0;
    logic        reset_n, ce, pause, rom_wr_i, rom_std_i;
    logic [14:0] rom_addr_i;
    logic [7:0]  rom_data_i;
    logic [29:0] drv_addr;
    logic        ph2_r, ph2_f, empty8k, ext_en;
    logic [7:0]  rom_data_o;
    logic [15:0] drv_data;
    logic [1:0]  rom_sz;
    logic        ph2_r_s, ph2_f_s, empty8k_s, ext_en_s;
    logic [7:0]  rom_data_o_s;
    logic [15:0] drv_data_s;
    logic [1:0]  rom_sz_s;

    int tests = 0;
    int fails = 0;
    int n;
    int strobes;

    always #5 clk = ~clk;

    iecdrv_shared_rom #(.DRIVES(2), .DUALROM(1'b1), .PARPORT(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .ce(ce), .pause(pause),
        .ph2_r(ph2_r), .ph2_f(ph2_f),
        .rom_addr_i(rom_addr_i), .rom_data_i(rom_data_i), .rom_wr_i(rom_wr_i),
        .rom_data_o(rom_data_o), .rom_std_i(rom_std_i),
        .drv_addr(drv_addr), .drv_data(drv_data),
        .rom_sz(rom_sz), .empty8k(empty8k), .ext_en(ext_en)
    );

    iecdrv_shared_rom #(.DRIVES(2), .DUALROM(1'b0), .PARPORT(1'b0)) dut_s (
        .clk(clk), .reset_n(reset_n), .ce(ce), .pause(pause),
        .ph2_r(ph2_r_s), .ph2_f(ph2_f_s),
        .rom_addr_i(rom_addr_i), .rom_data_i(rom_data_i), .rom_wr_i(rom_wr_i),
        .rom_data_o(rom_data_o_s), .rom_std_i(rom_std_i),
        .drv_addr(drv_addr), .drv_data(drv_data_s),
        .rom_sz(rom_sz_s), .empty8k(empty8k_s), .ext_en(ext_en_s)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [14:0] a, input logic [7:0] d);
        rom_addr_i = a;
        rom_data_i = d;
        rom_wr_i   = 1'b1;
        @(posedge clk); #1;
        rom_wr_i   = 1'b0;
    endtask

    // Clocks until the requested strobe is seen; 64 means it never came.
    task automatic wait_strobe(input bit fall, output int cnt);
        cnt = 0;
        for (int i = 0; i < 64; i++) begin
            @(posedge clk); #1;
            cnt++;
            if (fall ? ph2_f : ph2_r) break;
        end
    endtask

    initial begin
        reset_n = 1'b0; ce = 1'b1; pause = 1'b0; rom_wr_i = 1'b0; rom_std_i = 1'b0;
        rom_addr_i = 15'd0; rom_data_i = 8'd0; drv_addr = 30'd0;
        repeat (3) @(negedge clk);
        check("rst_ph2_r", ph2_r, 1'b0);
        check("rst_ph2_f", ph2_f, 1'b0);
        check("rst_drv_data", drv_data, 16'h0000);
        check("rst_rom_sz", rom_sz, 2'b11);
        check("rst_empty8k", empty8k, 1'b1);
        check("rst_ext_en", ext_en, 1'b1);
        check("rst_ext_en_s", ext_en_s, 1'b0);
        reset_n = 1'b1;

        // phi2 timing
        wait_strobe(1'b1, n);
        check("first_ph2f_clk", n, 9);
        @(posedge clk); #1;
        check("ph2f_width", ph2_f, 1'b0);
        wait_strobe(1'b0, n);
        check("ph2f_to_ph2r", n, 7);
        @(posedge clk); #1;
        check("ph2r_width", ph2_r, 1'b0);
        wait_strobe(1'b1, n);
        check("ph2r_to_ph2f", n, 7);

        // size detection
        wr(15'h5000, 8'h55);
        @(posedge clk); #1;
        check("sz_after_5000", rom_sz, 2'b11);
        check("empty_after_5000", empty8k, 1'b1);
        check("ext_after_5000", ext_en, 1'b1);
        wr(15'h0100, 8'h34);
        @(posedge clk); #1;
        check("empty_after_0100", empty8k, 1'b0);
        check("ext_after_0100", ext_en, 1'b0);
        check("sz_after_0100", rom_sz, 2'b00);
        wr(15'h2000, 8'h12);
        @(posedge clk); #1;
        check("sz_after_2000", rom_sz, 2'b01);

        // fetch: 16K alt mirrors 0x6000 onto 0x2000
        drv_addr = {15'h0100, 15'h6000};
        wait_strobe(1'b1, n);
        check("sync_fetch1", n < 64, 1'b1);
        repeat (8) @(posedge clk);
        #1;
        check("fetch_alt", drv_data, 16'h3412);
        check("fetch_std_mirror", drv_data_s, 16'h3412);
        drv_addr = {15'h5000, 15'h0000};
        repeat (4) @(posedge clk);
        #1;
        check("fetch_hold", drv_data, 16'h3412);

        // fetch from standard ROM, top address boundary
        wr(15'h0010, 8'h3C);
        wr(15'h3FFF, 8'hC3);
        rom_std_i = 1'b1;
        drv_addr = {15'h3FFF, 15'h0010};
        wait_strobe(1'b1, n);
        check("sync_fetch2", n < 64, 1'b1);
        repeat (8) @(posedge clk);
        #1;
        check("fetch_std", drv_data_s, 16'hC33C);
        check("ext_stdrom", ext_en, 1'b0);

        // loader readback and blank writes
        wr(15'h0007, 8'hA5);
        @(posedge clk); #1;
        check("readback_alt", rom_data_o, 8'hA5);
        check("readback_std", rom_data_o_s, 8'hA5);
        check("sz_after_0007", rom_sz, 2'b00);
        wr(15'h7000, 8'hFF);
        wr(15'h4000, 8'h00);
        @(posedge clk); #1;
        check("sz_blank_writes", rom_sz, 2'b00);
        wr(15'h0000, 8'h00);
        check("empty_set_addr0", empty8k, 1'b1);
        wr(15'h00FF, 8'h77);
        check("empty_page0", empty8k, 1'b1);

        // pause stops strobes
        pause = 1'b1;
        repeat (3) @(posedge clk);
        strobes = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (ph2_r || ph2_f) strobes++;
        end
        check("pause_strobes", strobes, 0);
        pause = 1'b0;

        // reset in the middle of a fetch sequence
        rom_std_i = 1'b0;
        wait_strobe(1'b1, n);
        check("sync_fetch3", n < 64, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("mid_rst_drv_data", drv_data, 16'h0000);
        check("mid_rst_drv_data_s", drv_data_s, 16'h0000);
        check("mid_rst_ph2_f", ph2_f, 1'b0);
        check("mid_rst_rom_sz", rom_sz, 2'b11);
        check("mid_rst_empty8k", empty8k, 1'b1);
        check("mid_rst_ext_en", ext_en, 1'b1);
        @(negedge clk);
        reset_n = 1'b1;
        wait_strobe(1'b1, n);
        check("post_rst_first_ph2f", n, 9);
        repeat (8) @(posedge clk);
        #1;
        check("post_rst_fetch_std", drv_data_s, 16'hC33C);
        rom_addr_i = 15'h0007;
        @(posedge clk); #1;
        check("post_rst_readback", rom_data_o, 8'hA5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
